// File: rtl/binary_divider_pkg.sv
// Shared definitions for the restoring shift-subtract divider.
package binary_divider_pkg;

    localparam int DIV_N = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/binary_divider_step.sv
// One restoring-division step: shift the partial remainder/quotient left and
// keep the trial subtraction only when it does not go negative.
module div_step #(
    parameter int N = 4
) (
    input  logic [2*N-1:0] acc,
    input  logic [N-1:0]   dvsr,
    output logic [2*N:0]   acc_next
);

    logic [2*N:0] shift_s;
    logic [N:0]   trial_s;

    // Shift, trial subtract and restore on a negative result.
    always_comb begin
        shift_s = {acc, 1'b0};
        trial_s = shift_s[2*N:N] - {1'b0, dvsr};
        if (trial_s[N] == 1'b0) begin
            acc_next = {trial_s, shift_s[N-1:1], 1'b1};
        end else begin
            acc_next = shift_s;
        end
    end

endmodule

// File: rtl/binary_divider.sv
// Sequential 2N/N unsigned divider, one quotient bit per clock, Start/Done handshake.
module binary_divider
    import binary_divider_pkg::*;
#(
    parameter int N = DIV_N
) (
    input  logic             clock,
    input  logic             Reset_n,
    input  logic             Start,
    input  logic [2*N-1:0]   dividend,
    input  logic [N-1:0]     divisor,
    output logic             Busy,
    output logic             Done,
    output logic             Overflow,
    output logic [N-1:0]     quotient,
    output logic [N-1:0]     remainder
);

    localparam int CW = $clog2(N + 1);

    state_e          state_r;
    logic [2*N:0]    acc_r;
    logic [N-1:0]    dvsr_r;
    logic [CW-1:0]   count_r;
    logic            ovf_r;
    logic [2*N:0]    acc_step_s;
    logic            accept_s;
    logic            ovf_now_s;

    div_step #(.N(N)) u_step (
        .acc      (acc_r[2*N-1:0]),
        .dvsr     (dvsr_r),
        .acc_next (acc_step_s)
    );

    assign accept_s  = Start && (state_r != ST_RUN);
    // A quotient wider than N bits (or a zero divisor) shows in the upper dividend half.
    assign ovf_now_s = (dividend[2*N-1:N] >= divisor);
    assign Busy      = (state_r == ST_RUN);

    // FSM, datapath registers and step counter.
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r <= ST_IDLE;
            acc_r   <= {(2*N+1){1'b0}};
            dvsr_r  <= {N{1'b0}};
            count_r <= {CW{1'b0}};
            ovf_r   <= 1'b0;
        end else if (accept_s) begin
            acc_r   <= {1'b0, dividend};
            dvsr_r  <= divisor;
            count_r <= CW'(N);
            ovf_r   <= ovf_now_s;
            state_r <= ovf_now_s ? ST_DONE : ST_RUN;
        end else if (state_r == ST_RUN) begin
            acc_r   <= acc_step_s;
            count_r <= count_r - {{(CW-1){1'b0}}, 1'b1};
            if (count_r == {{(CW-1){1'b0}}, 1'b1}) begin
                state_r <= ST_DONE;
            end else begin
                state_r <= ST_RUN;
            end
        end else begin
            state_r <= state_r;
        end
    end

    // Registered result decode; a set acc MSB in DONE is impossible and is reported as overflow.
    always_ff @(posedge clock or negedge Reset_n) begin
        if (!Reset_n) begin
            Done      <= 1'b0;
            Overflow  <= 1'b0;
            quotient  <= {N{1'b0}};
            remainder <= {N{1'b0}};
        end else if (state_r == ST_DONE) begin
            Done <= 1'b1;
            if (ovf_r || acc_r[2*N]) begin
                Overflow  <= 1'b1;
                quotient  <= {N{1'b0}};
                remainder <= {N{1'b0}};
            end else begin
                Overflow  <= 1'b0;
                quotient  <= acc_r[N-1:0];
                remainder <= acc_r[2*N-1:N];
            end
        end else begin
            Done      <= 1'b0;
            Overflow  <= 1'b0;
            quotient  <= {N{1'b0}};
            remainder <= {N{1'b0}};
        end
    end

endmodule

// File: doc/binary_divider.md
# binary_divider

Sequential restoring shift-subtract divider: divides a 2N-bit unsigned dividend by an N-bit unsigned divisor and produces an N-bit quotient and an N-bit remainder, one quotient bit per clock. It is the inverse of the lab's shift-add binary multiplier. A product from the multiplier (lower 2N bits) is fed back with one of its factors and must return the other factor with remainder 0. It uses the same Start/Done command style as the multiplier.

## Interface
- N, default 4: divisor, quotient and remainder width. Dividend is 2N bits.
- clock  in  1  rising-edge clock.
- Reset_n  in  1  reset, asynchronous, active-low.
- Start  in  1  command pulse. Sampled on the rising edge of clock.
- dividend  in  2N  unsigned dividend, captured on accepted Start.
- divisor  in  N  unsigned divisor, captured on accepted Start.
- Busy  out  1  high while in RUN.
- Done  out  1  high in DONE. Holds until the next accepted Start.
- Overflow  out  1  valid when Done is high. Set when the quotient does not fit in N bits or the divisor is 0.
- quotient  out  N  valid when Done is high and Overflow is low. 0 otherwise.
- remainder  out  N  valid when Done is high and Overflow is low. 0 otherwise.

## Operation
- States: IDLE, RUN, DONE.
- Registers:
  - acc, 2N+1 bits.
  - dvsr_reg, N bits.
  - count, ceil(log2(N+1)) bits.
  - ovf, 1 bit.
- Start is accepted in IDLE or DONE. Start in RUN is ignored, and the operation in progress is not disturbed.
- On accepted Start:
  - acc <= {1'b0, dividend}; dvsr_reg <= divisor; count <= N.
  - If dividend[2N-1:N] >= divisor, which covers divisor = 0: ovf <= 1 and the next state is DONE.
  - Otherwise: ovf <= 0 and the next state is RUN.
- Each RUN cycle:
  - Shift: s = {acc[2N-1:0], 1'b0}.
  - Trial subtract: t = s[2N:N] - {1'b0, dvsr_reg}, computed N+1 bits wide.
  - If t is non-negative (t[N] == 0): acc <= {t, s[N-1:1], 1'b1}.
  - Otherwise: acc <= s.
  - count <= count - 1. When count reaches 1 on that edge, the next state is DONE.
- Results in DONE with ovf = 0: quotient = acc[N-1:0], remainder = acc[2N-1:N]. acc[2N] is always 0 in DONE.
- Outputs outside DONE, and in DONE with ovf = 1: quotient = 0, remainder = 0. The outputs are never high-impedance.
- Invariant for every non-overflow case: quotient*divisor + remainder == dividend and remainder < divisor.

## Timing
- Reset (Reset_n low, asynchronous):
  - State IDLE.
  - acc, dvsr_reg, count and ovf are all 0.
  - Busy = 0, Done = 0, Overflow = 0, quotient = 0, remainder = 0.
- Reset asserted mid-RUN aborts immediately. No Done follows.
- Release: the first Start is honoured on the first rising edge after Reset_n goes high.
- Latency, normal case:
  - Start is sampled on edge E0.
  - Busy is high from E0 to E0+N.
  - Done rises after edge E0+N+1.
  - That is N+1 cycles for N = 4 gives 5 cycles.
- Latency, overflow case: Done and Overflow rise after E0+1. Busy never asserts.
- Start in DONE: the new operation starts on that same edge. Done falls the cycle after the edge, so back-to-back operations need no IDLE gap.
- Inputs dividend and divisor are sampled only at the accepting edge. Changes during RUN have no effect.
- All outputs are decoded from registers. There are no combinational paths from inputs to outputs.

## Structure
- Package binary_divider_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a default width constant DIV_N = 4.
- One combinational sub-module, div_step: takes acc and dvsr_reg and returns the next acc, implementing the shift and trial subtract.
  - The top module keeps the FSM, count and output decode.
  - div_step is unit-testable on its own.

## Test plan
- Reset held low, then released with no Start: all outputs 0 and Busy 0 for 20 cycles.
- dividend = 100, divisor = 7, N = 4: Busy for 4 cycles, then Done with quotient = 14, remainder = 2 and Overflow = 0, exactly 5 edges after Start. Done holds until the next Start.
- dividend = 225, divisor = 15: quotient = 15, remainder = 0. Exhaustive sweep of all non-overflow pairs checks q*d + r == dividend and r < d.
- Overflow cases: both must give Done after 1 edge with Overflow = 1, quotient = 0 and remainder = 0, and Busy never rises.
  - dividend = 0x80, divisor = 4.
  - dividend = 0x05, divisor = 0.
- Start pulsed on cycle 2 of a 100/7 RUN, with dividend changed to 50: the result is still 14 r 2, and Done is on schedule.
- Reset_n pulsed low during RUN: outputs 0 asynchronously. A following 60/5 request completes with quotient = 12, remainder = 0. A back-to-back Start in DONE with 9/2 gives quotient = 4, remainder = 1 five cycles later.
